// File: rtl/imu_seq_pkg.sv
// Shared types and command tables for the IMU command sequencer.
// Command word layout: {R/W_n, addr[6:0], data[7:0]}.
package ebike_imu_pkg;

  typedef enum logic [2:0] {
    PWRUP, CFG_SND, CFG_WAIT, IDLE, RD_SND, RD_WAIT
  } imu_seq_state_t;

  localparam logic [6:0] REG_INT1_CTRL = 7'h0D;
  localparam logic [6:0] REG_CTRL1_XL  = 7'h10;
  localparam logic [6:0] REG_CTRL2_G   = 7'h11;
  localparam logic [6:0] REG_PITCH_L   = 7'h22;
  localparam logic [6:0] REG_PITCH_H   = 7'h23;
  localparam logic [6:0] REG_AZ_L      = 7'h2C;
  localparam logic [6:0] REG_AZ_H      = 7'h2D;

  function automatic logic [15:0] mk_cmd(input logic rd, input logic [6:0] addr,
                                         input logic [7:0] data);
    return {rd, addr, data};
  endfunction

  localparam logic [15:0] CFG_CMD [0:2] = '{
    mk_cmd(1'b0, REG_INT1_CTRL, 8'h02),
    mk_cmd(1'b0, REG_CTRL1_XL,  8'h53),
    mk_cmd(1'b0, REG_CTRL2_G,   8'h50)
  };

  localparam logic [15:0] RD_CMD [0:3] = '{
    mk_cmd(1'b1, REG_PITCH_L, 8'h00),
    mk_cmd(1'b1, REG_PITCH_H, 8'h00),
    mk_cmd(1'b1, REG_AZ_L,    8'h00),
    mk_cmd(1'b1, REG_AZ_H,    8'h00)
  };

endpackage

// File: rtl/imu_seq_if.sv
// Command/response link between the IMU sequencer and the SPI monarch.
interface imu_seq_if;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output snd, cmd, input done, resp);
  modport slave  (input snd, cmd, output done, resp);
endinterface

// File: rtl/imu_seq_sync_rise.sv
// Two-flop synchronizer with a one-clock rising-edge pulse on the output.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], d};
  end

  assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/imu_seq.sv
// IMU command sequencer: power-up wait, three config writes, then a
// four-read burst per data-ready interrupt producing pitch rate and Z accel.
module imu_seq
  import ebike_imu_pkg::*;
#(
  parameter int PWRUP_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         INT,
  imu_seq_if.master    spi,
  output logic [15:0]  pitch_rt,
  output logic [15:0]  AZ,
  output logic         vld,
  output logic         cfg_done
);

  imu_seq_state_t     state, nxt;
  logic [1:0]         idx;
  logic [PWRUP_W-1:0] pwr_cnt;
  logic               pending, done_q, int_rise, done_rise;
  logic [7:0]         hold0, hold1, hold2;
  logic [15:0]        cmd_q;
  logic               idx_clr, idx_inc, cfg_set, pend_clr, hold_we, upd;

  sync_rise u_int_sync (.clk(clk), .rst_n(rst_n), .d(INT), .rise(int_rise));

  // Completion is the done edge only; done stays high between transactions.
  assign done_rise = spi.done & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PWRUP;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    spi.snd  = 1'b0;
    spi.cmd  = cmd_q;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    cfg_set  = 1'b0;
    pend_clr = 1'b0;
    hold_we  = 1'b0;
    upd      = 1'b0;
    unique case (state)
      PWRUP: if (&pwr_cnt) begin
        nxt     = CFG_SND;
        idx_clr = 1'b1;
      end
      CFG_SND: begin
        spi.snd = 1'b1;
        spi.cmd = CFG_CMD[idx];
        nxt     = CFG_WAIT;
      end
      CFG_WAIT: if (done_rise) begin
        if (idx == 2'd2) begin
          cfg_set = 1'b1;
          nxt     = IDLE;
        end else begin
          idx_inc = 1'b1;
          nxt     = CFG_SND;
        end
      end
      IDLE: if (int_rise || pending) begin
        nxt      = RD_SND;
        idx_clr  = 1'b1;
        pend_clr = 1'b1;
      end
      RD_SND: begin
        spi.snd = 1'b1;
        spi.cmd = RD_CMD[idx];
        nxt     = RD_WAIT;
      end
      RD_WAIT: if (done_rise) begin
        hold_we = 1'b1;
        if (idx == 2'd3) begin
          upd = 1'b1;
          nxt = IDLE;
        end else begin
          idx_inc = 1'b1;
          nxt     = RD_SND;
        end
      end
      default: nxt = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      pwr_cnt  <= '0;
      pending  <= 1'b0;
      done_q   <= 1'b0;
      cmd_q    <= '0;
      cfg_done <= 1'b0;
      hold0    <= '0;
      hold1    <= '0;
      hold2    <= '0;
      pitch_rt <= '0;
      AZ       <= '0;
      vld      <= 1'b0;
    end else begin
      done_q <= spi.done;
      cmd_q  <= spi.cmd;
      vld    <= upd;
      if (state == PWRUP) pwr_cnt <= pwr_cnt + 1'b1;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 2'd1;
      if (cfg_set) cfg_done <= 1'b1;
      // One-deep pending: interrupts before configuration completes are dropped.
      if (pend_clr) pending <= 1'b0;
      else if (int_rise && cfg_done && state != IDLE) pending <= 1'b1;
      if (hold_we) begin
        case (idx)
          2'd0:    hold0 <= spi.resp[7:0];
          2'd1:    hold1 <= spi.resp[7:0];
          2'd2:    hold2 <= spi.resp[7:0];
          default: ;
        endcase
      end
      // Both outputs update together so they always come from one sample.
      if (upd) begin
        pitch_rt <= {hold1, hold0};
        AZ       <= {spi.resp[7:0], hold2};
      end
    end
  end

endmodule

// File: tb/tb_imu_seq.sv
// Bench for imu_seq with a behavioural SPI monarch + IMU register model.
module tb_imu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_in = 1'b0;
  logic [15:0] pitch_rt, AZ;
  logic        vld, cfg_done;

  always #5 clk = ~clk;

  imu_seq_if bus();

  imu_seq #(.PWRUP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(int_in), .spi(bus),
    .pitch_rt(pitch_rt), .AZ(AZ), .vld(vld), .cfg_done(cfg_done)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] obs_cmd[$];
  logic [15:0] exp_cmd[$];
  logic [31:0] obs_vld[$];
  logic [31:0] exp_vld[$];
  logic [7:0]  regs [0:127];
  bit          snd_twice = 0;
  bit          vld_twice = 0;

  // SPI monarch + IMU: three clocks after snd, done rises and stays high.
  initial begin : spi_model
    logic [15:0] cur;
    int          lat;
    bit          busy, prev_snd;
    cur = '0; lat = 0; busy = 0; prev_snd = 0;
    bus.done = 1'b0;
    bus.resp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        bus.done = 1'b0;
      end else if (bus.snd === 1'b1) begin
        if (prev_snd) snd_twice = 1;
        obs_cmd.push_back(bus.cmd);
        cur = bus.cmd;
        bus.done = 1'b0;
        lat = 3;
        busy = 1;
      end else if (busy) begin
        if (lat > 1) lat--;
        else begin
          busy = 0;
          if (cur[15]) bus.resp = {8'h00, regs[cur[14:8]]};
          else begin
            regs[cur[14:8]] = cur[7:0];
            bus.resp = 16'h0000;
          end
          bus.done = 1'b1;
        end
      end
      prev_snd = (bus.snd === 1'b1) && rst_n;
    end
  end

  initial begin : vld_mon
    bit pv;
    pv = 0;
    forever begin
      @(negedge clk);
      if (vld === 1'b1) begin
        obs_vld.push_back({pitch_rt, AZ});
        if (pv) vld_twice = 1;
      end
      pv = (vld === 1'b1);
    end
  end

  task automatic wait_cmds(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (obs_cmd.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_vld(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (obs_vld.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_int();
    int_in = 1'b1;
    repeat (2) @(negedge clk);
    int_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_cfg();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150);
  endtask

  task automatic push_rd();
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    exp_cmd.push_back(16'hAD00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.snd !== 1'b0)     begin n_err++; $display("FAIL reset_snd got %h want 0", bus.snd); end
    n_cmp++; if (bus.cmd !== 16'h0000) begin n_err++; $display("FAIL reset_cmd got %h want 0000", bus.cmd); end
    n_cmp++; if (pitch_rt !== 16'h0)   begin n_err++; $display("FAIL reset_pitch got %h want 0000", pitch_rt); end
    n_cmp++; if (AZ !== 16'h0)         begin n_err++; $display("FAIL reset_az got %h want 0000", AZ); end
    n_cmp++; if (vld !== 1'b0)         begin n_err++; $display("FAIL reset_vld got %h want 0", vld); end
    n_cmp++; if (cfg_done !== 1'b0)    begin n_err++; $display("FAIL reset_cfg_done got %h want 0", cfg_done); end
  endtask

  // Release reset, time first snd, pulse INT in PWRUP and mid-config.
  task automatic test_cfg(input string tag);
    int          cnt;
    bit          ok;
    logic [15:0] o, e;
    obs_cmd.delete();
    exp_cmd.delete();
    push_cfg();
    rst_n = 1'b1;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 3) int_in = 1'b1;
      if (cnt == 6) int_in = 1'b0;
      if (bus.snd === 1'b1) break;
    end
    int_in = 1'b0;
    n_cmp++; if (cnt != 16) begin n_err++; $display("FAIL %s_pwrup_clks got %0d want 16", tag, cnt); end
    wait_cmds(1, 50, ok);
    pulse_int();
    wait_cmds(3, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_cfg_timeout got %0d cmds want 3", tag, obs_cmd.size()); end
    while (exp_cmd.size() > 0) begin
      e = exp_cmd.pop_front();
      o = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL %s_cfg_cmd got %h want %h", tag, o, e); end
    end
    for (int i = 0; i < 50 && cfg_done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (cfg_done !== 1'b1) begin n_err++; $display("FAIL %s_cfg_done got %h want 1", tag, cfg_done); end
    n_cmp++; if (obs_vld.size() != 0) begin n_err++; $display("FAIL %s_cfg_vld got %0d pulses want 0", tag, obs_vld.size()); end
  endtask

  task automatic test_int_ignored();
    repeat (40) @(negedge clk);
    n_cmp++; if (obs_cmd.size() != 0) begin n_err++; $display("FAIL early_int_cmds got %0d want 0", obs_cmd.size()); end
    n_cmp++; if (obs_vld.size() != 0) begin n_err++; $display("FAIL early_int_vld got %0d want 0", obs_vld.size()); end
  endtask

  task automatic test_read();
    bit          ok;
    logic [15:0] o, e;
    logic [31:0] ov, ev;
    regs[7'h22] = 8'h34; regs[7'h23] = 8'h12; regs[7'h2C] = 8'hCD; regs[7'h2D] = 8'hAB;
    obs_cmd.delete(); obs_vld.delete();
    push_rd();
    exp_vld.push_back({16'h1234, 16'hABCD});
    pulse_int();
    wait_cmds(4, 200, ok);
    wait_vld(1, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL read_timeout got %0d vld want 1", obs_vld.size()); end
    while (exp_cmd.size() > 0) begin
      e = exp_cmd.pop_front();
      o = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL read_cmd got %h want %h", o, e); end
    end
    ev = exp_vld.pop_front();
    ov = (obs_vld.size() > 0) ? obs_vld.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (ov !== ev) begin n_err++; $display("FAIL read_sample got %h want %h", ov, ev); end
    repeat (3) @(negedge clk);
    n_cmp++; if (vld_twice || obs_vld.size() != 0) begin n_err++; $display("FAIL read_vld_width got extra=%0d twice=%0d want 0", obs_vld.size(), vld_twice); end
    n_cmp++; if (pitch_rt !== 16'h1234 || AZ !== 16'hABCD) begin n_err++; $display("FAIL read_hold got %h/%h want 1234/abcd", pitch_rt, AZ); end
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [15:0] o, e;
    logic [31:0] ov, ev;
    regs[7'h22] = 8'h78; regs[7'h23] = 8'h56; regs[7'h2C] = 8'h21; regs[7'h2D] = 8'h43;
    obs_cmd.delete(); obs_vld.delete();
    push_rd(); push_rd();
    exp_vld.push_back({16'h5678, 16'h4321});
    exp_vld.push_back({16'h5678, 16'h4321});
    pulse_int();
    wait_cmds(1, 50, ok);
    pulse_int();
    pulse_int();
    wait_cmds(8, 400, ok);
    wait_vld(2, 200, ok);
    repeat (40) @(negedge clk);
    n_cmp++; if (obs_cmd.size() != 8) begin n_err++; $display("FAIL b2b_cmd_count got %0d want 8", obs_cmd.size()); end
    n_cmp++; if (obs_vld.size() != 2) begin n_err++; $display("FAIL b2b_vld_count got %0d want 2", obs_vld.size()); end
    while (exp_cmd.size() > 0) begin
      e = exp_cmd.pop_front();
      o = (obs_cmd.size() > 0) ? obs_cmd.pop_front() : 16'hxxxx;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL b2b_cmd got %h want %h", o, e); end
    end
    while (exp_vld.size() > 0) begin
      ev = exp_vld.pop_front();
      ov = (obs_vld.size() > 0) ? obs_vld.pop_front() : 32'hxxxxxxxx;
      n_cmp++; if (ov !== ev) begin n_err++; $display("FAIL b2b_sample got %h want %h", ov, ev); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    obs_cmd.delete(); obs_vld.delete();
    pulse_int();
    wait_cmds(2, 200, ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.snd !== 1'b0 || bus.cmd !== 16'h0) begin n_err++; $display("FAIL mid_rst_bus got snd=%h cmd=%h want 0/0000", bus.snd, bus.cmd); end
    n_cmp++; if (pitch_rt !== 16'h0 || AZ !== 16'h0) begin n_err++; $display("FAIL mid_rst_data got %h/%h want 0000/0000", pitch_rt, AZ); end
    n_cmp++; if (vld !== 1'b0 || cfg_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got vld=%h cfg=%h want 0/0", vld, cfg_done); end
    n_cmp++; if (obs_vld.size() != 0) begin n_err++; $display("FAIL mid_rst_vld got %0d want 0", obs_vld.size()); end
    @(negedge clk);
    test_cfg("restart");
  endtask

  task automatic test_done_held();
    obs_cmd.delete(); obs_vld.delete();
    repeat (30) @(negedge clk);
    n_cmp++; if (obs_cmd.size() != 0 || obs_vld.size() != 0) begin n_err++; $display("FAIL done_held got cmds=%0d vld=%0d want 0/0", obs_cmd.size(), obs_vld.size()); end
    n_cmp++; if (snd_twice) begin n_err++; $display("FAIL snd_width got back-to-back snd want single"); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    test_reset();
    test_cfg("boot");
    test_int_ignored();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_done_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
